// File: rtl/mem_responder.sv
// mem_responder: RAM responder returning fixed-latency, in-order read data.
// A host write port preloads the RAM; writes block read acceptance for that cycle.
module mem_responder #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_OUTSTANDING = 3,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_wr_en,
    input  logic [ADDR_WIDTH-1:0] h_wr_addr,
    input  logic [DATA_WIDTH-1:0] h_wr_data,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_rsp_vld,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic [OW-1:0]         outstanding
);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);
    logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0] data_pipe [RD_LATENCY];
    logic                  accept;
    logic                  retire;
    logic [OW-1:0]         cnt_nxt;
    always_comb begin
        m_req_rdy = rst_n && !h_wr_en && (outstanding < MAX_CNT);
        accept    = m_req_vld && m_req_rdy;
        retire    = m_rsp_vld;
        cnt_nxt   = (accept && !retire) ? outstanding + OW'(1) :
                    (!accept && retire) ? outstanding - OW'(1) : outstanding;
    end
    assign m_rsp_vld  = vld_pipe[RD_LATENCY-1];
    assign m_rsp_data = data_pipe[RD_LATENCY-1];
    always_ff @(posedge clk)
        if (h_wr_en) mem[h_wr_addr] <= h_wr_data;
    // data stages only load behind a valid bit, so the output holds between responses
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            outstanding <= '0;
            vld_pipe    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) data_pipe[i] <= '0;
        end else begin
            outstanding <= cnt_nxt;
            vld_pipe[0] <= accept;
            if (accept) data_pipe[0] <= mem[m_req_addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
endmodule
